// File: rtl/reorder_buffer_nway_pkg.sv
// Shared types and helpers for the N-way reorder buffer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rob_pkg;

  localparam int DEST_W = 7;

  // Per-entry control state. The result payload lives in a separate
  // unreset array because its width is a module parameter.
  typedef struct packed {
    logic              busy;
    logic              done;
    logic [DEST_W-1:0] dest;
  } rob_entry_t;

  // Tags are 1-based so that 0 can mean "no tag". Callers must screen
  // out tag 0 themselves; it maps to the last index here.
  function automatic int unsigned tag_to_idx(input int unsigned tag, input int unsigned depth);
    return (tag - 1) & (depth - 1);
  endfunction

endpackage

// File: rtl/reorder_buffer_nway_if.sv
// Dispatch / completion / operand-read / commit bundle of the reorder buffer.
// Latency: n/a (wiring only).
// Backpressure: disp_ready_o gates dispatch; cmt_ready_i accepts all offered commit lanes.
interface rob_if #(
  parameter int DEPTH      = 32,
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int DATA_W     = 64
);
  localparam int TW = $clog2(DEPTH) + 1;

  logic [DISPATCH_W-1:0]                disp_valid_i;
  logic [DISPATCH_W*rob_pkg::DEST_W-1:0] disp_dest_i;
  logic                                 disp_ready_o;
  logic [DISPATCH_W*TW-1:0]             disp_tag_o;

  logic                                 cmpl_valid_i;
  logic [TW-1:0]                        cmpl_tag_i;
  logic [DATA_W-1:0]                    cmpl_data_i;

  logic [2*TW-1:0]                      rd_tag_i;
  logic [1:0]                           rd_done_o;
  logic [2*DATA_W-1:0]                  rd_data_o;

  logic [COMMIT_W-1:0]                  cmt_valid_o;
  logic [COMMIT_W*rob_pkg::DEST_W-1:0]   cmt_dest_o;
  logic [COMMIT_W*DATA_W-1:0]           cmt_data_o;
  logic                                 cmt_ready_i;

  // Pipeline front end / retire stage side
  modport master (
    output disp_valid_i, disp_dest_i, cmpl_valid_i, cmpl_tag_i, cmpl_data_i,
    output rd_tag_i, cmt_ready_i,
    input  disp_ready_o, disp_tag_o, rd_done_o, rd_data_o,
    input  cmt_valid_o, cmt_dest_o, cmt_data_o
  );

  // Reorder buffer side
  modport slave (
    input  disp_valid_i, disp_dest_i, cmpl_valid_i, cmpl_tag_i, cmpl_data_i,
    input  rd_tag_i, cmt_ready_i,
    output disp_ready_o, disp_tag_o, rd_done_o, rd_data_o,
    output cmt_valid_o, cmt_dest_o, cmt_data_o
  );

endinterface

// File: rtl/reorder_buffer_nway_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer.
// Latency: pointers and count update on the clock edge after accept/retire.
// Backpressure: disp_ready drops when fewer than DISPATCH_W entries are free.
module rob_ptr_ctrl #(
  parameter int DEPTH      = 32,
  parameter int DISPATCH_W = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic [$clog2(DEPTH):0]     acc_cnt,
  input  logic [$clog2(DEPTH):0]     ret_cnt,
  output logic [$clog2(DEPTH)-1:0]   head,
  output logic [$clog2(DEPTH)-1:0]   tail,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       disp_ready,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = AW + 1;

  // Pointers wrap naturally at AW bits; flush has priority over any traffic.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + acc_cnt[AW-1:0];
      head  <= head + ret_cnt[AW-1:0];
      count <= count + acc_cnt - ret_cnt;
    end
  end

  // Ready looks only at current occupancy, not at same-cycle retirement.
  always_comb begin
    disp_ready = (TW'(DEPTH) - count) >= TW'(DISPATCH_W);
    full       = (count == TW'(DEPTH));
    empty      = (count == '0);
  end

endmodule

// File: rtl/reorder_buffer_nway.sv
// N-way dispatch / N-way in-order commit reorder buffer with operand bypass.
// Latency: completion visible to commit 1 cycle later; read port bypasses same cycle.
// Backpressure: dispatch only when disp_ready_o; commit lanes retire together on cmt_ready_i.
module reorder_buffer_nway
  import rob_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int DATA_W     = 64
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  rob_if.slave                   bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = AW + 1;

  rob_entry_t        ent_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [AW-1:0]           head, tail;
  logic                    disp_ready;
  logic [TW-1:0]           acc_cnt, ret_cnt;
  logic [DISPATCH_W-1:0]   acc_lane;
  logic [AW-1:0]           disp_idx [DISPATCH_W];
  logic [DISPATCH_W*TW-1:0] disp_tag;
  logic                    disp_run;
  logic [COMMIT_W-1:0]     cmt_valid;
  logic [AW-1:0]           cmt_idx  [COMMIT_W];
  logic                    cmt_run;
  logic [AW-1:0]           cmpl_idx;
  logic                    cmpl_hit;
  logic [TW-1:0]           rd_tag   [2];
  logic [AW-1:0]           rd_idx   [2];

  rob_ptr_ctrl #(
    .DEPTH      (DEPTH),
    .DISPATCH_W (DISPATCH_W)
  ) u_ptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flush_i    (flush_i),
    .acc_cnt    (acc_cnt),
    .ret_cnt    (ret_cnt),
    .head       (head),
    .tail       (tail),
    .count      (count_o),
    .disp_ready (disp_ready),
    .full       (full_o),
    .empty      (empty_o)
  );

  assign bus.disp_ready_o = disp_ready;
  assign bus.disp_tag_o   = disp_tag;
  assign bus.cmt_valid_o  = cmt_valid;

  // Lane tags follow the tail; only the leading run of valid lanes is accepted.
  always_comb begin
    acc_cnt  = '0;
    disp_run = disp_ready;
    disp_tag = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      disp_idx[k]          = tail + AW'(k);
      disp_tag[k*TW +: TW] = {1'b0, disp_idx[k]} + TW'(1);
      acc_lane[k]          = disp_run && bus.disp_valid_i[k];
      disp_run             = acc_lane[k];
      acc_cnt              = acc_cnt + TW'(acc_lane[k]);
    end
  end

  // Commit offers the leading run of finished entries from head; flush mutes it.
  always_comb begin
    ret_cnt        = '0;
    cmt_run        = !flush_i;
    bus.cmt_dest_o = '0;
    bus.cmt_data_o = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      cmt_idx[k]   = head + AW'(k);
      cmt_valid[k] = cmt_run && ent_q[cmt_idx[k]].busy && ent_q[cmt_idx[k]].done;
      cmt_run      = cmt_valid[k];
      bus.cmt_dest_o[k*DEST_W +: DEST_W] = ent_q[cmt_idx[k]].dest;
      bus.cmt_data_o[k*DATA_W +: DATA_W] = data_q[cmt_idx[k]];
      if (bus.cmt_ready_i) begin
        ret_cnt = ret_cnt + TW'(cmt_valid[k]);
      end
    end
  end

  // A completion lands only on a live entry; stale or null tags are dropped.
  always_comb begin
    cmpl_idx = AW'(tag_to_idx(32'(bus.cmpl_tag_i), DEPTH));
    cmpl_hit = bus.cmpl_valid_i && (bus.cmpl_tag_i != '0) && ent_q[cmpl_idx].busy;
  end

  // Operand lookup, forwarding a completion that arrives in the same cycle.
  always_comb begin
    bus.rd_done_o = '0;
    bus.rd_data_o = '0;
    for (int r = 0; r < 2; r++) begin
      rd_tag[r] = bus.rd_tag_i[r*TW +: TW];
      rd_idx[r] = AW'(tag_to_idx(32'(rd_tag[r]), DEPTH));
      if ((rd_tag[r] != '0) && ent_q[rd_idx[r]].busy) begin
        if (bus.cmpl_valid_i && (bus.cmpl_tag_i == rd_tag[r])) begin
          bus.rd_done_o[r]                   = 1'b1;
          bus.rd_data_o[r*DATA_W +: DATA_W]  = bus.cmpl_data_i;
        end else begin
          bus.rd_done_o[r]                   = ent_q[rd_idx[r]].done;
          bus.rd_data_o[r*DATA_W +: DATA_W]  = data_q[rd_idx[r]];
        end
      end
    end
  end

  // Entry control state: completion, allocation and retirement all land together.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      if (cmpl_hit) begin
        ent_q[cmpl_idx].done <= 1'b1;
      end
      for (int k = 0; k < DISPATCH_W; k++) begin
        if (acc_lane[k]) begin
          ent_q[disp_idx[k]] <= '{busy: 1'b1, done: 1'b0,
                                  dest: bus.disp_dest_i[k*DEST_W +: DEST_W]};
        end
      end
      if (bus.cmt_ready_i) begin
        for (int k = 0; k < COMMIT_W; k++) begin
          if (cmt_valid[k]) begin
            ent_q[cmt_idx[k]].busy <= 1'b0;
            ent_q[cmt_idx[k]].done <= 1'b0;
          end
        end
      end
    end
  end

  // Result payload needs no reset; busy gating keeps stale values invisible.
  always_ff @(posedge clk_i) begin
    if (!flush_i && cmpl_hit) begin
      data_q[cmpl_idx] <= bus.cmpl_data_i;
    end
  end

endmodule
